// File: rtl/cd_bufram_arbiter.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cd_bufram_arbiter : NUM_CH-way fixed/round-robin arbiter onto the CD buffer-RAM port.
// Revision 1.0
// ----------------------------------------------------------------------------
module cd_bufram_arbiter #(
  parameter int NUM_CH  = 3,
  parameter int AW      = 18,
  parameter int DW      = 16,
  parameter int RAM_LAT = 2,
  parameter int RR_MODE = 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     ce_i,
  input  logic [NUM_CH-1:0]        req_i,
  input  logic [NUM_CH-1:0]        wr_i,
  input  logic [NUM_CH*(DW/8)-1:0] be_i,
  input  logic [NUM_CH*AW-1:0]     addr_i,
  input  logic [NUM_CH*DW-1:0]     wdata_i,
  output logic [NUM_CH-1:0]        ack_o,
  output logic [DW-1:0]            rdata_o,
  output logic [2:0]               gnt_ch_o,
  output logic                     busy_o,
  output logic [AW-1:0]            ram_a_o,
  output logic [DW-1:0]            ram_d_o,
  input  logic [DW-1:0]            ram_q_i,
  output logic                     ram_cs_o,
  output logic [(DW/8)-1:0]        ram_we_o,
  output logic                     ram_rd_o
);

  localparam int         BL       = DW / 8;
  localparam logic [3:0] LAT_LOAD = 4'(RAM_LAT - 1);
  localparam logic [3:0] NUM_CH4  = 4'(NUM_CH);
  localparam logic [2:0] LAST_CH  = 3'(NUM_CH - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [2:0]        ptr_q, ptr_d;
  logic [2:0]        gnt_q, gnt_d;
  logic              busy_q, busy_d;
  logic              cs_q, cs_d;
  logic              rd_q, rd_d;
  logic [BL-1:0]     we_q, we_d;
  logic [AW-1:0]     a_q, a_d;
  logic [DW-1:0]     d_q, d_d;
  logic [DW-1:0]     rdata_q, rdata_d;
  logic [NUM_CH-1:0] ack_q, ack_d;

  logic [7:0]        req_ext;
  logic [2:0]        base;
  logic [3:0]        cand;
  logic              win_vld;
  logic [2:0]        win_idx;
  logic              win_wr;
  logic [BL-1:0]     win_be;
  logic [AW-1:0]     win_addr;
  logic [DW-1:0]     win_wdata;
  logic [NUM_CH-1:0] ack_gnt;
  logic [2:0]        ptr_next;

  // Search starts at the RR pointer (or 0 in fixed mode) and wraps once.
  always_comb begin
    req_ext             = '0;
    req_ext[NUM_CH-1:0] = req_i;
    base                = (RR_MODE != 0) ? ptr_q : 3'd0;
    cand                = '0;
    win_vld             = 1'b0;
    win_idx             = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      cand = {1'b0, base} + 4'(k);
      if (cand >= NUM_CH4) begin
        cand = cand - NUM_CH4;
      end
      if (!win_vld && req_ext[cand[2:0]]) begin
        win_vld = 1'b1;
        win_idx = cand[2:0];
      end
    end
  end

  always_comb begin
    win_wr    = 1'b0;
    win_be    = '0;
    win_addr  = '0;
    win_wdata = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_idx == 3'(i)) begin
        win_wr    = wr_i[i];
        win_be    = be_i[i*BL +: BL];
        win_addr  = addr_i[i*AW +: AW];
        win_wdata = wdata_i[i*DW +: DW];
      end
    end
  end

  always_comb begin
    ack_gnt = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ack_gnt[i] = (gnt_q == 3'(i));
    end
    ptr_next = (gnt_q == LAST_CH) ? 3'd0 : gnt_q + 3'd1;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    busy_d  = busy_q;
    cs_d    = cs_q;
    rd_d    = rd_q;
    we_d    = we_q;
    a_d     = a_q;
    d_d     = d_q;
    rdata_d = rdata_q;
    ack_d   = ack_q;
    case (state_q)
      S_IDLE: begin
        if (win_vld) begin
          gnt_d   = win_idx;
          busy_d  = 1'b1;
          cs_d    = 1'b1;
          rd_d    = ~win_wr;
          we_d    = win_wr ? win_be : '0;
          a_d     = win_addr;
          d_d     = win_wdata;
          cnt_d   = LAT_LOAD;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          if (rd_q) begin
            rdata_d = ram_q_i;
          end
          cs_d    = 1'b0;
          rd_d    = 1'b0;
          we_d    = '0;
          ack_d   = ack_gnt;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        // Dead cycle: a requester that drops REQ on ACK is never re-granted.
        ack_d   = '0;
        busy_d  = 1'b0;
        if (RR_MODE != 0) begin
          ptr_d = ptr_next;
        end
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      cs_q    <= 1'b0;
      rd_q    <= 1'b0;
      we_q    <= '0;
      a_q     <= '0;
      d_q     <= '0;
      rdata_q <= '0;
      ack_q   <= '0;
    end else if (ce_i) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      cs_q    <= cs_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      a_q     <= a_d;
      d_q     <= d_d;
      rdata_q <= rdata_d;
      ack_q   <= ack_d;
    end
  end

  assign ack_o    = ack_q;
  assign rdata_o  = rdata_q;
  assign gnt_ch_o = gnt_q;
  assign busy_o   = busy_q;
  assign ram_a_o  = a_q;
  assign ram_d_o  = d_q;
  assign ram_cs_o = cs_q;
  assign ram_we_o = we_q;
  assign ram_rd_o = rd_q;

endmodule
`default_nettype wire

// File: tb/tb_cd_bufram_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_cd_bufram_arbiter : directed bench for cd_bufram_arbiter (RR, fixed, RAM_LAT=3).
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_cd_bufram_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ce  = 1'b1;
  logic [2:0]  req = '0;
  logic [2:0]  wr  = '0;
  logic [5:0]  be  = '0;
  logic [53:0] addr  = '0;
  logic [47:0] wdata = '0;

  logic [2:0]  m_ack, f_ack, l_ack;
  logic [15:0] m_rdata, f_rdata, l_rdata;
  logic [2:0]  m_gnt, f_gnt, l_gnt;
  logic        m_busy, f_busy, l_busy;
  logic [17:0] m_a, f_a, l_a;
  logic [15:0] m_d, f_d, l_d;
  logic [15:0] m_q, f_q, l_q;
  logic        m_cs, f_cs, l_cs;
  logic [1:0]  m_we, f_we, l_we;
  logic        m_rd, f_rd, l_rd;

  logic [15:0] mem [0:262143];

  int          sel = 0;
  logic [2:0]  s_ack;
  logic [15:0] s_rdata;
  logic [2:0]  s_gnt;
  logic        s_busy, s_cs, s_rd;
  logic [17:0] s_a;
  logic [15:0] s_d;
  logic [1:0]  s_we;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  cd_bufram_arbiter #(.NUM_CH(3), .AW(18), .DW(16), .RAM_LAT(2), .RR_MODE(1)) u_main (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .req_i(req), .wr_i(wr), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .ack_o(m_ack), .rdata_o(m_rdata),
    .gnt_ch_o(m_gnt), .busy_o(m_busy), .ram_a_o(m_a), .ram_d_o(m_d),
    .ram_q_i(m_q), .ram_cs_o(m_cs), .ram_we_o(m_we), .ram_rd_o(m_rd)
  );

  cd_bufram_arbiter #(.NUM_CH(3), .AW(18), .DW(16), .RAM_LAT(2), .RR_MODE(0)) u_fix (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .req_i(req), .wr_i(wr), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .ack_o(f_ack), .rdata_o(f_rdata),
    .gnt_ch_o(f_gnt), .busy_o(f_busy), .ram_a_o(f_a), .ram_d_o(f_d),
    .ram_q_i(f_q), .ram_cs_o(f_cs), .ram_we_o(f_we), .ram_rd_o(f_rd)
  );

  cd_bufram_arbiter #(.NUM_CH(3), .AW(18), .DW(16), .RAM_LAT(3), .RR_MODE(1)) u_lat3 (
    .clk_i(clk), .rst_i(rst), .ce_i(ce), .req_i(req), .wr_i(wr), .be_i(be),
    .addr_i(addr), .wdata_i(wdata), .ack_o(l_ack), .rdata_o(l_rdata),
    .gnt_ch_o(l_gnt), .busy_o(l_busy), .ram_a_o(l_a), .ram_d_o(l_d),
    .ram_q_i(l_q), .ram_cs_o(l_cs), .ram_we_o(l_we), .ram_rd_o(l_rd)
  );

  assign m_q = mem[m_a];
  assign f_q = mem[f_a];
  assign l_q = mem[l_a];

  // Only the main instance writes the shared RAM model.
  always @(posedge clk) begin
    if (rst) begin
      mem[18'h01234] <= 16'hBEEF;
      mem[18'h00010] <= 16'h1234;
      mem[18'h00555] <= 16'h7A7A;
      mem[18'h3FFFF] <= 16'hCAFE;
    end else if (ce && m_cs) begin
      for (int b = 0; b < 2; b++) begin
        if (m_we[b]) mem[m_a][b*8 +: 8] <= m_d[b*8 +: 8];
      end
    end
  end

  always_comb begin
    case (sel)
      1: begin
        s_ack = f_ack; s_rdata = f_rdata; s_gnt = f_gnt; s_busy = f_busy;
        s_cs = f_cs; s_rd = f_rd; s_a = f_a; s_d = f_d; s_we = f_we;
      end
      2: begin
        s_ack = l_ack; s_rdata = l_rdata; s_gnt = l_gnt; s_busy = l_busy;
        s_cs = l_cs; s_rd = l_rd; s_a = l_a; s_d = l_d; s_we = l_we;
      end
      default: begin
        s_ack = m_ack; s_rdata = m_rdata; s_gnt = m_gnt; s_busy = m_busy;
        s_cs = m_cs; s_rd = m_rd; s_a = m_a; s_d = m_d; s_we = m_we;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ce  = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_ch(input int ch, input logic w, input logic [1:0] b,
                        input logic [17:0] a, input logic [15:0] d);
    wr[ch]          = w;
    be[ch*2 +: 2]   = b;
    addr[ch*18 +: 18] = a;
    wdata[ch*16 +: 16] = d;
  endtask

  // Ticks until the selected instance pulses ACK or the budget runs out (lat=0).
  task automatic wait_ack(input int max_cyc, output int lat, output int cs_cnt,
                          output logic [2:0] ack_seen, output logic [1:0] we_or);
    lat = 0; cs_cnt = 0; ack_seen = '0; we_or = '0;
    for (int i = 1; i <= max_cyc; i++) begin
      tick();
      if (s_cs) cs_cnt++;
      we_or = we_or | s_we;
      if (s_ack != 3'b000) begin
        lat      = i;
        ack_seen = s_ack;
        break;
      end
    end
  endtask

  initial begin
    int         lat, cs_cnt, ack_cnt;
    logic [2:0] ack_seen;
    logic [1:0] we_or;

    // Reset state
    sel = 0;
    do_reset();
    chk("rst_busy",  32'(s_busy),  32'h0);
    chk("rst_cs",    32'(s_cs),    32'h0);
    chk("rst_ack",   32'(s_ack),   32'h0);
    chk("rst_gnt",   32'(s_gnt),   32'h0);
    chk("rst_rdata", 32'(s_rdata), 32'h0);
    chk("rst_ram_a", 32'(s_a),     32'h0);

    // Single read on ch1
    set_ch(1, 1'b0, 2'b00, 18'h01234, 16'h0000);
    req = 3'b010;
    tick();
    chk("rd_cs",   32'(s_cs),  32'h1);
    chk("rd_rd",   32'(s_rd),  32'h1);
    chk("rd_a",    32'(s_a),   32'h01234);
    chk("rd_gnt",  32'(s_gnt), 32'h1);
    chk("rd_busy", 32'(s_busy), 32'h1);
    wait_ack(8, lat, cs_cnt, ack_seen, we_or);
    chk("rd_lat",   32'(lat + 1),    32'd3);
    chk("rd_cs_cy", 32'(cs_cnt + 1), 32'd2);
    chk("rd_ack",   32'(ack_seen),   32'b010);
    chk("rd_rdata", 32'(s_rdata),    32'hBEEF);
    req = 3'b000;
    tick();
    chk("rd_ack_clr", 32'(s_ack),  32'h0);
    chk("rd_busy_clr", 32'(s_busy), 32'h0);

    // Upper-byte write on ch0
    set_ch(0, 1'b1, 2'b10, 18'h00010, 16'hA55A);
    req = 3'b001;
    tick();
    chk("wr_we", 32'(s_we), 32'b10);
    chk("wr_d",  32'(s_d),  32'hA55A);
    chk("wr_rd", 32'(s_rd), 32'h0);
    chk("wr_a",  32'(s_a),  32'h00010);
    wait_ack(8, lat, cs_cnt, ack_seen, we_or);
    chk("wr_ack",   32'(ack_seen), 32'b001);
    chk("wr_rdata", 32'(s_rdata),  32'hBEEF);
    req = 3'b000;
    tick();
    chk("wr_mem", 32'(mem[18'h00010]), 32'hA534);

    // Round-robin vs fixed priority with all requests held
    do_reset();
    set_ch(0, 1'b0, 2'b00, 18'h00100, 16'h0);
    set_ch(1, 1'b0, 2'b00, 18'h00200, 16'h0);
    set_ch(2, 1'b0, 2'b00, 18'h00300, 16'h0);
    req = 3'b111;
    for (int n = 0; n < 6; n++) begin
      wait_ack(10, lat, cs_cnt, ack_seen, we_or);
      chk("rr_gnt", 32'(s_gnt), 32'(n % 3));
      chk("fix_ack", 32'(f_ack), 32'b001);
    end
    req = 3'b000;
    tick();

    // CE toggling on the RAM_LAT=3 instance
    sel = 2;
    do_reset();
    set_ch(2, 1'b0, 2'b00, 18'h00555, 16'h0);
    req = 3'b100;
    cs_cnt = 0; ack_cnt = 0; ack_seen = '0;
    for (int i = 0; i < 14; i++) begin
      tick();
      if (s_cs) cs_cnt++;
      if (s_ack != 3'b000) begin
        ack_cnt++;
        ack_seen = s_ack;
        req = 3'b000;
      end
      ce = ~ce;
    end
    ce = 1'b1;
    chk("ce_cs_clk",  32'(cs_cnt),   32'd6);
    chk("ce_ack_clk", 32'(ack_cnt),  32'd2);
    chk("ce_ack",     32'(ack_seen), 32'b100);
    chk("ce_rdata",   32'(s_rdata),  32'h7A7A);

    // Reset in the middle of a ch1 access
    sel = 0;
    do_reset();
    set_ch(1, 1'b0, 2'b00, 18'h00100, 16'h0);
    req = 3'b010;
    tick();
    tick();
    chk("mr_cs_pre", 32'(s_cs), 32'h1);
    rst = 1'b1;
    req = 3'b100;
    tick();
    chk("mr_cs",   32'(s_cs),   32'h0);
    chk("mr_busy", 32'(s_busy), 32'h0);
    chk("mr_ack",  32'(s_ack),  32'h0);
    chk("mr_gnt",  32'(s_gnt),  32'h0);
    rst = 1'b0;
    tick();
    chk("mr_regnt", 32'(s_gnt), 32'h2);
    wait_ack(8, lat, cs_cnt, ack_seen, we_or);
    chk("mr_ack2", 32'(ack_seen), 32'b100);
    req = 3'b000;
    tick();

    // All-ones address, write with no byte enables
    set_ch(0, 1'b1, 2'b00, 18'h3FFFF, 16'h1111);
    req = 3'b001;
    tick();
    chk("bz_a",  32'(s_a),  32'h3FFFF);
    chk("bz_we", 32'(s_we), 32'h0);
    chk("bz_cs", 32'(s_cs), 32'h1);
    chk("bz_rd", 32'(s_rd), 32'h0);
    wait_ack(8, lat, cs_cnt, ack_seen, we_or);
    chk("bz_lat",   32'(lat + 1),  32'd3);
    chk("bz_we_or", 32'(we_or),    32'h0);
    chk("bz_ack",   32'(ack_seen), 32'b001);
    req = 3'b000;
    tick();
    chk("bz_mem", 32'(mem[18'h3FFFF]), 32'hCAFE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
